// File: rtl/carry_look_4b.sv
// carry_look_4b: registered 4-bit carry-lookahead adder/subtractor slice.
// Computes a + (sub ? ~b : b) + c with flat sum-of-products carries and
// exports carry-out, signed overflow and group propagate/generate for cascading.
module carry_look_4b (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  input  logic       sub,
  output logic [3:0] r,
  output logic       co,
  output logic       ovf,
  output logic       pg,
  output logic       gg
);

  localparam int unsigned W = 4;

  logic [W-1:0] bx;
  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   cy;
  logic [W-1:0] sum;
  logic         pg_n;
  logic         gg_n;

  // Operand prep, per-bit terms and flat lookahead carries (no ripple).
  always_comb begin
    bx = sub ? ~b : b;
    p  = a ^ bx;
    g  = a & bx;

    cy    = '0;
    cy[0] = c;
    cy[1] = g[0] | (p[0] & c);
    cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c);

    sum  = p ^ cy[W-1:0];

    // Group terms are independent of carry-in so a second-level unit can use them.
    pg_n = &p;
    gg_n = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

  // Single output register stage; reset wins over the data load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r   <= '0;
      co  <= 1'b0;
      ovf <= 1'b0;
      pg  <= 1'b0;
      gg  <= 1'b0;
    end else begin
      r   <= sum;
      co  <= cy[4];
      ovf <= cy[4] ^ cy[3];
      pg  <= pg_n;
      gg  <= gg_n;
    end
  end

endmodule

// File: tb/tb_carry_look_4b.sv
// tb_carry_look_4b: scoreboard bench for carry_look_4b.
// Driver pushes the expected result for each cycle; monitor pops one per edge.
module tb_carry_look_4b;

  typedef struct {
    logic [3:0] r;
    logic       co;
    logic       ovf;
    logic       pg;
    logic       gg;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       c;
  logic       sub;
  logic [3:0] r;
  logic       co;
  logic       ovf;
  logic       pg;
  logic       gg;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  carry_look_4b dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .sub (sub),
    .r   (r),
    .co  (co),
    .ovf (ovf),
    .pg  (pg),
    .gg  (gg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] er, input logic eco, input logic eovf,
                              input logic epg, input logic egg, input string nm);
    exp_t e;
    e.r = er; e.co = eco; e.ovf = eovf; e.pg = epg; e.gg = egg; e.name = nm;
    return e;
  endfunction

  // Arithmetic reference: integer sum, signed range check, group terms from c=0 carry.
  function automatic exp_t model(input logic [3:0] ta, input logic [3:0] tb_v,
                                 input logic tc, input logic tsub);
    exp_t e;
    logic [3:0] bx;
    int s;
    int sa;
    int sbx;
    int sv;
    bx  = tsub ? ~tb_v : tb_v;
    s   = int'(ta) + int'(bx) + int'(tc);
    sa  = ta[3] ? int'(ta) - 16 : int'(ta);
    sbx = bx[3] ? int'(bx) - 16 : int'(bx);
    sv  = sa + sbx + int'(tc);
    e.r    = 4'(s);
    e.co   = (s > 15);
    e.ovf  = (sv > 7) || (sv < -8);
    e.pg   = ((ta ^ bx) == 4'hf);
    e.gg   = ((int'(ta) + int'(bx)) > 15);
    e.name = "sweep";
    return e;
  endfunction

  task automatic drive(input logic trst, input logic [3:0] ta, input logic [3:0] tb_v,
                       input logic tc, input logic tsub, input exp_t e);
    @(negedge clk);
    rst = trst; a = ta; b = tb_v; c = tc; sub = tsub;
    sb.push_back(e);
  endtask

  // Monitor: every edge presents a result; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (r !== e.r || co !== e.co || ovf !== e.ovf || pg !== e.pg || gg !== e.gg) begin
          errors++;
          $display("FAIL %s: got r=%0d co=%b ovf=%b pg=%b gg=%b, want r=%0d co=%b ovf=%b pg=%b gg=%b",
                   e.name, r, co, ovf, pg, gg, e.r, e.co, e.ovf, e.pg, e.gg);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; a = 4'd15; b = 4'd15; c = 1'b1; sub = 1'b0;

    // Reset held two edges with busy inputs, then release.
    drive(1'b1, 4'd15, 4'd15, 1'b1, 1'b0, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset0"));
    drive(1'b1, 4'd15, 4'd15, 1'b1, 1'b0, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset1"));
    drive(1'b0, 4'd15, 4'd15, 1'b1, 1'b0, mk(4'd15, 1'b1, 1'b0, 1'b0, 1'b1, "release"));

    // Directed vectors, back-to-back with no bubbles.
    drive(1'b0, 4'd2,  4'd7,  1'b0, 1'b0, mk(4'd9,  1'b0, 1'b1, 1'b0, 1'b0, "add_2_7"));
    drive(1'b0, 4'd4,  4'd3,  1'b1, 1'b1, mk(4'd1,  1'b1, 1'b0, 1'b0, 1'b1, "sub_4_3"));
    drive(1'b0, 4'd3,  4'd4,  1'b1, 1'b1, mk(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, "borrow_3_4"));
    drive(1'b0, 4'd15, 4'd1,  1'b0, 1'b0, mk(4'd0,  1'b1, 1'b0, 1'b0, 1'b1, "wrap_15_1"));
    drive(1'b0, 4'd5,  4'd10, 1'b1, 1'b0, mk(4'd0,  1'b1, 1'b0, 1'b1, 1'b0, "prop_5_10"));
    drive(1'b0, 4'd7,  4'd1,  1'b0, 1'b0, mk(4'd8,  1'b0, 1'b1, 1'b0, 1'b0, "ovf_7_1"));
    drive(1'b0, 4'd5,  4'd3,  1'b0, 1'b1, mk(4'd1,  1'b1, 1'b0, 1'b0, 1'b1, "sub_nocin"));
    drive(1'b0, 4'd8,  4'd1,  1'b1, 1'b1, mk(4'd7,  1'b1, 1'b1, 1'b0, 1'b1, "sub_ovf"));
    drive(1'b0, 4'd0,  4'd0,  1'b0, 1'b0, mk(4'd0,  1'b0, 1'b0, 1'b0, 1'b0, "zero"));

    // Reset mid-stream discards the sampled operation.
    drive(1'b1, 4'd9,  4'd9,  1'b1, 1'b0, mk(4'd0,  1'b0, 1'b0, 1'b0, 1'b0, "mid_reset"));
    drive(1'b0, 4'd6,  4'd6,  1'b0, 1'b0, mk(4'd12, 1'b0, 1'b1, 1'b0, 1'b0, "after_reset"));

    // Full sweep of a, b, c, sub against the arithmetic reference.
    for (int i = 0; i < 1024; i++) begin
      logic [3:0] ta;
      logic [3:0] tbv;
      logic       tc;
      logic       ts;
      ta  = 4'(i);
      tbv = 4'(i >> 4);
      tc  = 1'(i >> 8);
      ts  = 1'(i >> 9);
      drive(1'b0, ta, tbv, tc, ts, model(ta, tbv, tc, ts));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
